// File: rtl/ir_command_filter.sv
// ============================================================================
// ir_command_filter
// ----------------------------------------------------------------------------
// Debounces the IR period detector's decision stream into a committed beacon
// command. A code becomes the command only after CONFIRM_COUNT consecutive
// identical decisions. If detector strobes stop for TIMEOUT_CYCLES clocks the
// command falls back to NONE and the timeout flag is raised until the next
// strobe arrives.
//
// Code encoding (detector code set, 3 bits):
//   0 = NONE, 1 = R_B, 2 = R_G, 3 = B_G, 4 = STOP; values 5..7 are read as NONE.
//
// Parameters:
//   CONFIRM_COUNT  - consecutive identical decisions needed to commit (1..15)
//   TIMEOUT_CYCLES - clk cycles without a done strobe before forcing NONE (>=1)
//
// Optional feature (macro IR_STOP_PRIORITY_EN):
//   defined   - a single STOP decision commits STOP immediately; leaving STOP
//               still needs a full streak of another code or a timeout.
//   undefined - STOP is filtered like every other code.
//
// Ports:
//   clk       in   system clock (100 MHz)
//   rst       in   synchronous active-high reset
//   done      in   one-cycle strobe from detector, qualifies decision
//   decision  in   [2:0] detector code
//   cmd       out  [2:0] committed command code
//   cmd_valid out  one-cycle pulse on the cycle cmd changes value
//   locked    out  high while cmd holds a confirmed non-NONE code
//   timeout   out  high while no done has arrived within TIMEOUT_CYCLES
// ============================================================================
module ir_command_filter #(
    parameter int CONFIRM_COUNT  = 4,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       done,
    input  logic [2:0] decision,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    output logic       locked,
    output logic       timeout
);

    localparam int NUM_CODES = 5;               // codes 0..4 are legal
    localparam logic [2:0] CODE_NONE = 3'd0;
`ifdef IR_STOP_PRIORITY_EN
    localparam logic [2:0] CODE_STOP = 3'd4;
`endif

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES);
    // Expiry fires on the edge where the timer would step onto TIMER_MAX, so
    // a done arriving while the timer sits at TIMER_MAX-1 still wins.
    localparam logic [TIMER_W-1:0] TIMER_PRE = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]         AGREE_MAX = 4'(CONFIRM_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONFIRM,
        ST_LOCKED
    } state_t;

    state_t              state_reg,     state_next;
    logic [2:0]          cand_reg,      cand_next;
    logic [3:0]          agree_reg,     agree_next;
    logic [TIMER_W-1:0]  timer_reg,     timer_next;
    logic [2:0]          cmd_reg,       cmd_next;
    logic                cmd_valid_reg, cmd_valid_next;
    logic                locked_reg,    locked_next;
    logic                timeout_reg,   timeout_next;

    // ------------------------------------------------------------------
    // Legal-code decode: anything outside the code set collapses to NONE.
    // ------------------------------------------------------------------
    logic [NUM_CODES-1:0] code_hit;
    logic [2:0]           dec_norm;

    generate
        for (genvar gi = 0; gi < NUM_CODES; gi++) begin : g_code_hit
            assign code_hit[gi] = (decision == 3'(gi));
        end
    endgenerate

    assign dec_norm = (|code_hit) ? decision : CODE_NONE;

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    logic commit;

    always_comb begin
        state_next     = state_reg;
        cand_next      = cand_reg;
        agree_next     = agree_reg;
        timer_next     = timer_reg;
        cmd_next       = cmd_reg;
        cmd_valid_next = 1'b0;
        timeout_next   = timeout_reg;
        commit         = 1'b0;

        if (done) begin
            // A strobe always reloads the timer, even on the expiry cycle.
            timer_next   = '0;
            timeout_next = 1'b0;

            if (dec_norm == cand_reg) begin
                agree_next = (agree_reg == AGREE_MAX) ? AGREE_MAX : agree_reg + 4'd1;
            end else begin
                cand_next  = dec_norm;
                agree_next = 4'd1;
            end

            // Commit decision uses the post-update streak length.
            commit = (agree_next == AGREE_MAX) && (cand_next != cmd_reg);
`ifdef IR_STOP_PRIORITY_EN
            if ((dec_norm == CODE_STOP) && (cmd_reg != CODE_STOP)) begin
                commit = 1'b1;
            end
`endif

            if (commit) begin
                cmd_next       = cand_next;
                cmd_valid_next = 1'b1;
                state_next     = (cand_next == CODE_NONE) ? ST_IDLE : ST_LOCKED;
            end else if ((state_reg == ST_IDLE) && (dec_norm != CODE_NONE)) begin
                state_next = ST_CONFIRM;
            end
        end else begin
            if (timer_reg != TIMER_MAX) begin
                timer_next = timer_reg + TIMER_W'(1);
            end
            // One-shot expiry: only the step onto TIMER_MAX triggers it.
            if (timer_reg == TIMER_PRE) begin
                timeout_next = 1'b1;
                cand_next    = CODE_NONE;
                agree_next   = 4'd0;
                state_next   = ST_IDLE;
                if (cmd_reg != CODE_NONE) begin
                    cmd_next       = CODE_NONE;
                    cmd_valid_next = 1'b1;
                end
            end
        end

        locked_next = (state_next == ST_LOCKED);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cand_reg      <= CODE_NONE;
            agree_reg     <= 4'd0;
            timer_reg     <= '0;
            cmd_reg       <= CODE_NONE;
            cmd_valid_reg <= 1'b0;
            locked_reg    <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cand_reg      <= cand_next;
            agree_reg     <= agree_next;
            timer_reg     <= timer_next;
            cmd_reg       <= cmd_next;
            cmd_valid_reg <= cmd_valid_next;
            locked_reg    <= locked_next;
            timeout_reg   <= timeout_next;
        end
    end

    assign cmd       = cmd_reg;
    assign cmd_valid = cmd_valid_reg;
    assign locked    = locked_reg;
    assign timeout   = timeout_reg;

endmodule

// File: tb/tb_ir_command_filter.sv
// ============================================================================
// tb_ir_command_filter
// ----------------------------------------------------------------------------
// Self-checking bench for ir_command_filter (CONFIRM_COUNT=4,
// TIMEOUT_CYCLES=200). Directed scenarios check against constants; the random
// scenario checks every cycle against a window-based reference model: a
// command commits when the last CONFIRM_COUNT strobes since the last
// reset/timeout all carry the same code and it differs from the current one.
// Honours IR_STOP_PRIORITY_EN the same way the design does.
// ============================================================================
module tb_ir_command_filter;

    localparam int CC  = 4;
    localparam int TMO = 200;

    localparam logic [2:0] NONE = 3'd0;
    localparam logic [2:0] R_B  = 3'd1;
    localparam logic [2:0] R_G  = 3'd2;
    localparam logic [2:0] B_G  = 3'd3;
    localparam logic [2:0] STOP = 3'd4;

    logic       clk;
    logic       rst;
    logic       done;
    logic [2:0] decision;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       locked;
    logic       timeout;

    ir_command_filter #(
        .CONFIRM_COUNT  (CC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .done      (done),
        .decision  (decision),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [5:0] obs;
    logic [5:0] e;
    assign obs = {cmd, cmd_valid, locked, timeout};

    // Reference model state
    logic [2:0] m_hist[$];
    logic [2:0] m_cmd     = NONE;
    logic       m_valid   = 1'b0;
    logic       m_timeout = 1'b0;
    int         m_idle    = 0;

    function automatic logic [5:0] ex(input logic [2:0] c, input logic v,
                                      input logic l, input logic t);
        return {c, v, l, t};
    endfunction

    // One clock: drive inputs, let the edge happen, advance the model, then
    // leave the outputs settled 1 time unit after the edge for sampling.
    task automatic tick(input bit r, input bit d, input logic [2:0] dec);
        logic [2:0] n;
        bit         same;
        rst      = r;
        done     = d;
        decision = dec;
        @(posedge clk);
        m_valid = 1'b0;
        if (r) begin
            m_hist.delete();
            m_cmd     = NONE;
            m_timeout = 1'b0;
            m_idle    = 0;
        end else if (d) begin
            m_idle    = 0;
            m_timeout = 1'b0;
            n = (dec <= 3'd4) ? dec : NONE;
            m_hist.push_back(n);
            if (m_hist.size() > CC) void'(m_hist.pop_front());
            same = (m_hist.size() == CC);
            foreach (m_hist[k]) if (m_hist[k] != n) same = 1'b0;
`ifdef IR_STOP_PRIORITY_EN
            if (n == STOP) same = 1'b1;
`endif
            if (same && (n != m_cmd)) begin
                m_cmd   = n;
                m_valid = 1'b1;
            end
        end else if (m_idle < TMO) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_timeout = 1'b1;
                m_hist.delete();
                if (m_cmd != NONE) begin
                    m_cmd   = NONE;
                    m_valid = 1'b1;
                end
            end
        end
        #1;
        rst  = 1'b0;
        done = 1'b0;
        cyc++;
        if (d)
            $display("txn cyc=%0d rst=%b dec=%0d -> cmd=%0d valid=%b locked=%b timeout=%b",
                     cyc, r, dec, cmd, cmd_valid, locked, timeout);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 3'($urandom_range(0, 7)));
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, NONE);
        tick(1'b1, 1'b0, NONE);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        e = ex(NONE, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL reset_state got=%b want=%b (cmd,valid,locked,timeout)", obs, e);
        end
    endtask

    task automatic test_confirm();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle(99);
            tick(1'b0, 1'b1, R_G);
            e = (i < 3) ? ex(NONE, 1'b0, 1'b0, 1'b0) : ex(R_G, 1'b1, 1'b1, 1'b0);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL confirm_strobe%0d got=%b want=%b (cmd,valid,locked,timeout)", i + 1, obs, e);
            end
        end
        tick(1'b0, 1'b0, NONE);
        e = ex(R_G, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL confirm_hold got=%b want=%b (cmd,valid,locked,timeout)", obs, e);
        end
    endtask

    task automatic test_streak_break();
        logic [2:0] seq [8];
        seq = '{R_B, R_B, R_B, B_G, R_B, R_B, R_B, R_B};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b1, seq[k]);
            e = (k < 7) ? ex(NONE, 1'b0, 1'b0, 1'b0) : ex(R_B, 1'b1, 1'b1, 1'b0);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL streak_break%0d got=%b want=%b (cmd,valid,locked,timeout)", k + 1, obs, e);
            end
        end
        tick(1'b0, 1'b1, R_B);
        e = ex(R_B, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL repeat_no_pulse got=%b want=%b (cmd,valid,locked,timeout)", obs, e);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b1, (k < 4) ? R_B : B_G);
            if (k == 3)      e = ex(R_B, 1'b1, 1'b1, 1'b0);
            else if (k < 3)  e = ex(NONE, 1'b0, 1'b0, 1'b0);
            else if (k < 7)  e = ex(R_B, 1'b0, 1'b1, 1'b0);
            else             e = ex(B_G, 1'b1, 1'b1, 1'b0);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL back_to_back%0d got=%b want=%b (cmd,valid,locked,timeout)", k + 1, obs, e);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        repeat (4) tick(1'b0, 1'b1, B_G);
        for (int n = 1; n <= TMO; n++) begin
            tick(1'b0, 1'b0, 3'($urandom_range(0, 7)));
            e = (n < TMO) ? ex(B_G, 1'b0, 1'b1, 1'b0) : ex(NONE, 1'b1, 1'b0, 1'b1);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL timeout_idle%0d got=%b want=%b (cmd,valid,locked,timeout)", n, obs, e);
            end
        end
        tick(1'b0, 1'b0, NONE);
        e = ex(NONE, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL timeout_level got=%b want=%b (cmd,valid,locked,timeout)", obs, e);
        end
        tick(1'b0, 1'b1, R_G);
        e = ex(NONE, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL timeout_clear got=%b want=%b (cmd,valid,locked,timeout)", obs, e);
        end
    endtask

    task automatic test_coincident();
        do_reset();
        repeat (4) tick(1'b0, 1'b1, B_G);
        idle(TMO - 1);
        tick(1'b0, 1'b1, B_G);
        e = ex(B_G, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL coincident_done got=%b want=%b (cmd,valid,locked,timeout)", obs, e);
        end
        idle(TMO - 1);
        e = ex(B_G, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL coincident_reload got=%b want=%b (cmd,valid,locked,timeout)", obs, e);
        end
        idle(1);
        e = ex(NONE, 1'b1, 1'b0, 1'b1);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL coincident_expire got=%b want=%b (cmd,valid,locked,timeout)", obs, e);
        end
    endtask

    task automatic test_reset_mid_streak();
        do_reset();
        repeat (3) tick(1'b0, 1'b1, R_G);
        tick(1'b1, 1'b1, R_G);              // reset wins over a coincident done
        e = ex(NONE, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL reset_mid got=%b want=%b (cmd,valid,locked,timeout)", obs, e);
        end
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 1'b1, R_G);
            e = (k < 3) ? ex(NONE, 1'b0, 1'b0, 1'b0) : ex(R_G, 1'b1, 1'b1, 1'b0);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL after_reset%0d got=%b want=%b (cmd,valid,locked,timeout)", k + 1, obs, e);
            end
        end
        tick(1'b1, 1'b0, NONE);
        e = ex(NONE, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL reset_locked got=%b want=%b (cmd,valid,locked,timeout)", obs, e);
        end
    endtask

    task automatic test_none_and_illegal();
        logic [2:0] seq [4];
        seq = '{3'd5, 3'd7, NONE, 3'd6};
        do_reset();
        repeat (4) tick(1'b0, 1'b1, R_G);
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 1'b1, seq[k]);
            e = (k < 3) ? ex(R_G, 1'b0, 1'b1, 1'b0) : ex(NONE, 1'b1, 1'b0, 1'b0);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL none_commit%0d got=%b want=%b (cmd,valid,locked,timeout)", k + 1, obs, e);
            end
        end
    endtask

    task automatic test_stop();
        do_reset();
        repeat (4) tick(1'b0, 1'b1, R_B);
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 1'b1, STOP);
`ifdef IR_STOP_PRIORITY_EN
            e = ex(STOP, (k == 0), 1'b1, 1'b0);
`else
            e = (k < 3) ? ex(R_B, 1'b0, 1'b1, 1'b0) : ex(STOP, 1'b1, 1'b1, 1'b0);
`endif
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL stop_strobe%0d got=%b want=%b (cmd,valid,locked,timeout)", k + 1, obs, e);
            end
        end
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 1'b1, R_B);
            e = (k < 3) ? ex(STOP, 1'b0, 1'b1, 1'b0) : ex(R_B, 1'b1, 1'b1, 1'b0);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL leave_stop%0d got=%b want=%b (cmd,valid,locked,timeout)", k + 1, obs, e);
            end
        end
    endtask

    task automatic test_random();
        int         gap;
        logic [2:0] fav;
        logic [2:0] dec;
        bit         d;
        bit         r;
        gap = 0;
        fav = R_B;
        for (int i = 0; i < 4000; i++) begin
            r   = 1'b0;
            d   = 1'b0;
            dec = 3'($urandom_range(0, 7));
            if (gap > 0) begin
                gap--;
            end else if ($urandom_range(0, 399) == 0) begin
                gap = $urandom_range(150, 260);
            end else if ($urandom_range(0, 599) == 0) begin
                r = 1'b1;
                d = ($urandom_range(0, 1) == 1);
            end else if ($urandom_range(0, 2) == 0) begin
                d = 1'b1;
                if ($urandom_range(0, 9) == 0) fav = 3'($urandom_range(0, 7));
                dec = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : fav;
            end
            tick(r, d, dec);
            e = ex(m_cmd, m_valid, (m_cmd != NONE), m_timeout);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL random_cyc%0d got=%b want=%b (cmd,valid,locked,timeout)", cyc, obs, e);
            end
        end
    endtask

    initial begin
        rst      = 1'b0;
        done     = 1'b0;
        decision = NONE;
        test_reset();
        test_confirm();
        test_streak_break();
        test_back_to_back();
        test_timeout();
        test_coincident();
        test_reset_mid_streak();
        test_none_and_illegal();
        test_stop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
